// File: rtl/branch_resolve.sv
// Branch resolution stage: turns one compare result into a branch-bus broadcast,
// an optional frontend redirect and a ROB completion, one branch at a time.
module branch_resolve #(
    parameter int NUM_TAGS  = 4,
    parameter int TAG_W     = $clog2(NUM_TAGS),
    parameter int ROB_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_result,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_imm,
    input  logic                 in_pred_taken,
    input  logic [31:0]          in_pred_target,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic [ROB_IDX_W-1:0] in_rob_idx,
    output logic                 brb_broadcast,
    output logic [TAG_W-1:0]     brb_tag,
    output logic                 brb_clean,
    output logic                 brb_kill,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    input  logic                 redirect_ready,
    output logic                 done_valid,
    output logic [ROB_IDX_W-1:0] done_rob_idx,
    output logic                 done_mispred,
    input  logic                 done_ready
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESOLVE  = 2'd1,
        REDIRECT = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    state_t                 state;
    logic [31:0]            next_pc_q;
    logic                   mispred_q;
    logic [ROB_IDX_W-1:0]   rob_idx_q;

    logic                   taken;
    logic [31:0]            target;
    logic [31:0]            fall;
    logic [31:0]            next_pc;
    logic                   mispred;
    logic                   unused_result;

    // Resolution is computed from the live inputs and captured on the accept edge only.
    assign taken         = in_result[0];
    assign unused_result = ^in_result[31:1];
    assign target        = in_pc + in_imm;
    assign fall          = in_pc + 32'd4;
    assign next_pc       = taken ? target : fall;
    assign mispred       = (taken != in_pred_taken) |
                           (taken & in_pred_taken & (in_pred_target != target));

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            next_pc_q      <= '0;
            mispred_q      <= 1'b0;
            rob_idx_q      <= '0;
            brb_broadcast  <= 1'b0;
            brb_tag        <= '0;
            brb_clean      <= 1'b0;
            brb_kill       <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            done_valid     <= 1'b0;
            done_rob_idx   <= '0;
            done_mispred   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state         <= RESOLVE;
                        next_pc_q     <= next_pc;
                        mispred_q     <= mispred;
                        rob_idx_q     <= in_rob_idx;
                        brb_broadcast <= 1'b1;
                        brb_tag       <= in_tag;
                        brb_clean     <= ~mispred;
                        brb_kill      <= mispred;
                    end
                end
                RESOLVE: begin
                    brb_broadcast <= 1'b0;
                    brb_tag       <= '0;
                    brb_clean     <= 1'b0;
                    brb_kill      <= 1'b0;
                    if (mispred_q) begin
                        state          <= REDIRECT;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= next_pc_q;
                    end else begin
                        state        <= COMPLETE;
                        done_valid   <= 1'b1;
                        done_rob_idx <= rob_idx_q;
                        done_mispred <= 1'b0;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= COMPLETE;
                        redirect_valid <= 1'b0;
                        redirect_pc    <= '0;
                        done_valid     <= 1'b1;
                        done_rob_idx   <= rob_idx_q;
                        done_mispred   <= mispred_q;
                    end
                end
                COMPLETE: begin
                    if (done_ready) begin
                        state        <= IDLE;
                        done_valid   <= 1'b0;
                        done_rob_idx <= '0;
                        done_mispred <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with hand-computed expected values.
module tb_branch_resolve;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic        in_pred_taken;
    logic [31:0] in_pred_target;
    logic [1:0]  in_tag;
    logic [4:0]  in_rob_idx;
    logic        brb_broadcast;
    logic [1:0]  brb_tag;
    logic        brb_clean;
    logic        brb_kill;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        done_valid;
    logic [4:0]  done_rob_idx;
    logic        done_mispred;
    logic        done_ready;

    int checks   = 0;
    int failures = 0;

    branch_resolve #(.NUM_TAGS(4), .TAG_W(2), .ROB_IDX_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_result      (in_result),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_pred_taken  (in_pred_taken),
        .in_pred_target (in_pred_target),
        .in_tag         (in_tag),
        .in_rob_idx     (in_rob_idx),
        .brb_broadcast  (brb_broadcast),
        .brb_tag        (brb_tag),
        .brb_clean      (brb_clean),
        .brb_kill       (brb_kill),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .done_valid     (done_valid),
        .done_rob_idx   (done_rob_idx),
        .done_mispred   (done_mispred),
        .done_ready     (done_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] res, input logic [31:0] pc, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptgt, input logic [1:0] tag,
                         input logic [4:0] rob);
        in_valid       = 1'b1;
        in_result      = res;
        in_pc          = pc;
        in_imm         = imm;
        in_pred_taken  = pt;
        in_pred_target = ptgt;
        in_tag         = tag;
        in_rob_idx     = rob;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_result = '0; in_pc = '0; in_imm = '0;
        in_pred_taken = 1'b0; in_pred_target = '0;
        in_tag = '0; in_rob_idx = '0;
        redirect_ready = 1'b1;
        done_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_broadcast", brb_broadcast, 0);
        check("rst_redirect_valid", redirect_valid, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_clean_kill", {brb_clean, brb_kill}, 0);
        step();
        rst = 1'b1;
        step();

        // Taken, correctly predicted
        drive(32'd1, 32'h100, 32'h20, 1'b1, 32'h120, 2'd1, 5'd3);
        step();
        in_valid = 1'b0;
        check("t1_broadcast", brb_broadcast, 1);
        check("t1_tag", brb_tag, 1);
        check("t1_clean", brb_clean, 1);
        check("t1_kill", brb_kill, 0);
        check("t1_in_ready", in_ready, 0);
        step();
        check("t1_no_redirect", redirect_valid, 0);
        check("t1_bcast_off", brb_broadcast, 0);
        check("t1_done_valid", done_valid, 1);
        check("t1_done_rob", done_rob_idx, 3);
        check("t1_done_mispred", done_mispred, 0);
        step();
        check("t1_idle", in_ready, 1);
        check("t1_done_off", done_valid, 0);

        // Taken, predicted not taken
        drive(32'd1, 32'h100, 32'hFFFF_FFF8, 1'b0, 32'h0, 2'd2, 5'd7);
        step();
        in_valid = 1'b0;
        check("t2_broadcast", brb_broadcast, 1);
        check("t2_tag", brb_tag, 2);
        check("t2_kill", brb_kill, 1);
        check("t2_clean", brb_clean, 0);
        step();
        check("t2_redirect_valid", redirect_valid, 1);
        check("t2_redirect_pc", redirect_pc, 32'hF8);
        check("t2_no_done", done_valid, 0);
        step();
        check("t2_redirect_off", redirect_valid, 0);
        check("t2_done_valid", done_valid, 1);
        check("t2_done_mispred", done_mispred, 1);
        check("t2_done_rob", done_rob_idx, 7);
        step();
        check("t2_idle", in_ready, 1);

        // Taken with wrong predicted target
        drive(32'd1, 32'h100, 32'h20, 1'b1, 32'h200, 2'd0, 5'd9);
        step();
        in_valid = 1'b0;
        check("t3_kill", brb_kill, 1);
        step();
        check("t3_redirect_pc", redirect_pc, 32'h120);
        step();
        check("t3_done_mispred", done_mispred, 1);
        step();

        // Not taken, predicted taken, fall-through wraps
        drive(32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h40, 1'b1, 32'h3C, 2'd3, 5'd1);
        step();
        in_valid = 1'b0;
        check("t4_kill", brb_kill, 1);
        step();
        check("t4_redirect_valid", redirect_valid, 1);
        check("t4_redirect_pc", redirect_pc, 32'h0);
        step();
        step();
        check("t4_idle", in_ready, 1);

        // Backpressure; a second branch waits on in_valid throughout
        redirect_ready = 1'b0;
        done_ready = 1'b0;
        drive(32'd1, 32'h100, 32'hFFFF_FFF8, 1'b0, 32'h0, 2'd2, 5'd12);
        step();
        drive(32'd0, 32'h500, 32'h80, 1'b0, 32'h0, 2'd3, 5'd20);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_redirect_valid", redirect_valid, 1);
            check("bp_redirect_pc", redirect_pc, 32'hF8);
            check("bp_in_ready", in_ready, 0);
            done_ready = 1'b1;
            step();
            done_ready = 1'b0;
        end
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_done_valid", done_valid, 1);
            check("bp_done_rob", done_rob_idx, 12);
            check("bp_done_mispred", done_mispred, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_no_bcast", brb_broadcast, 0);
            redirect_ready = 1'b1;
            step();
            redirect_ready = 1'b0;
        end
        done_ready = 1'b1;
        redirect_ready = 1'b1;
        step();
        check("bp_idle", in_ready, 1);
        check("bp_done_off", done_valid, 0);
        step();
        in_valid = 1'b0;
        check("bp2_broadcast", brb_broadcast, 1);
        check("bp2_tag", brb_tag, 3);
        check("bp2_clean", brb_clean, 1);
        step();
        check("bp2_done_rob", done_rob_idx, 20);
        check("bp2_done_mispred", done_mispred, 0);
        step();
        check("bp2_idle", in_ready, 1);

        // Reset while in REDIRECT
        redirect_ready = 1'b0;
        drive(32'd1, 32'h100, 32'hFFFF_FFF8, 1'b0, 32'h0, 2'd1, 5'd5);
        step();
        in_valid = 1'b0;
        step();
        check("rm_in_redirect", redirect_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rm_in_ready", in_ready, 1);
        check("rm_redirect_off", redirect_valid, 0);
        step();
        rst = 1'b1;
        redirect_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rm_no_done", done_valid, 0);
            check("rm_no_bcast", brb_broadcast, 0);
        end
        drive(32'd1, 32'h100, 32'h20, 1'b1, 32'h120, 2'd2, 5'd4);
        step();
        in_valid = 1'b0;
        check("rm_next_clean", brb_clean, 1);
        check("rm_next_tag", brb_tag, 2);
        step();
        check("rm_next_done", done_valid, 1);
        check("rm_next_rob", done_rob_idx, 4);
        step();
        check("rm_next_idle", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
